// File: rtl/key_spi_trigger_pkg.sv
// Shared definitions for the key-to-SPI trigger path: transfer FSM states
// and default widths, also imported by the SPI master side.
package key_spi_trigger_pkg;

    // Default SPI payload width
    localparam int unsigned SPI_DATA_W = 8;

    // Default debounce window in clocks and the matching counter width
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEFAULT_CNT_W           = 5;

    // Transfer handshake states
    typedef enum logic [1:0] {
        StIdle = 2'd0,  // nothing in flight
        StPend = 2'd1,  // press accepted, waiting for the master to be free
        StAck  = 2'd2,  // start issued, waiting for the master to raise busy
        StXfer = 2'd3   // master busy with our byte
    } spi_state_e;

endpackage

// File: rtl/key_spi_trigger_debounce.sv
// Reusable key front end: 2-flop synchroniser, stability counter and
// press edge detector for one active-low push-button.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic pressed,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    // The synced level is accepted once it has disagreed for the full window
    assign accept = (sync2_q != stable_q) && (cnt_q == CntLast);

    // Bring the asynchronous key into the clock domain (idles released)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else if (sync2_q == stable_q) begin
            cnt_q <= '0;
        end else if (accept) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // One-cycle pulse coinciding with the accepted 1->0 (press) transition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= accept && !sync2_q;
        end
    end

    assign pressed     = ~stable_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/key_spi_trigger.sv
// Push-button to SPI master trigger: one start/busy handshake per accepted
// press, carrying an incrementing sequence byte. One press may be queued
// while a transfer is in flight; further presses set a sticky overrun flag.
module key_spi_trigger
    import key_spi_trigger_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W,
    parameter int unsigned DATA_W          = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              pressed,
    output logic              press_pulse
    ,
    output logic              overrun
);

    spi_state_e        state_q;
    logic              queued_q;
    logic              overrun_q;
    logic              tx_start_q;
    logic [DATA_W-1:0] tx_data_q;
    logic [DATA_W-1:0] seq_q;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key_debounce (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .pressed     (pressed),
        .press_pulse (press_pulse)
    );

    // Handshake FSM with registered start/data, press queue and overrun flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            queued_q   <= 1'b0;
            overrun_q  <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            seq_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A fresh press and a queued one arriving together merge
                    if (press_pulse || queued_q) begin
                        state_q  <= StPend;
                        queued_q <= 1'b0;
                        if (!tx_busy) begin
                            tx_start_q <= 1'b1;
                            tx_data_q  <= seq_q;
                        end
                    end
                end
                StPend: begin
                    if (tx_start_q) begin
                        tx_start_q <= 1'b0;
                        state_q    <= StAck;
                    end else if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= seq_q;
                    end
                end
                StAck: begin
                    if (tx_busy) begin
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    if (!tx_busy) begin
                        state_q <= StIdle;
                        seq_q   <= seq_q + DATA_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Presses seen while a transfer is in flight fill the single slot
            if (press_pulse && (state_q != StIdle)) begin
                if (!queued_q) begin
                    queued_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_key_spi_trigger.sv
// Self-checking bench for key_spi_trigger: directed scenarios plus random
// key activity, compared every cycle against a behavioural model. The bench
// also plays the SPI master, answering each start with a busy window.
module tb_key_spi_trigger;

    localparam int unsigned D  = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          button;
    logic          tx_busy;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          pressed;
    logic          press_pulse;
    logic          overrun;

    key_spi_trigger #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW),
        .DATA_W          (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .pressed     (pressed),
        .press_pulse (press_pulse),
        .overrun     (overrun)
    );

    always #1 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: key delay line, accepted level, disagreement run,
    // and the transfer lifecycle (0 none, 1 awaiting grant, 2 granted,
    // 3 master busy) with a one-deep press slot.
    bit      m_s1, m_s2, m_lvl, m_pulse, m_start, m_queued, m_overrun;
    int      m_run, m_phase, m_seq;
    bit [7:0] m_data;

    // Bench-side SPI master and DUT activity observed at the sample point
    bit seen_start;
    int ms_wait, ms_len, ms_fix;
    bit force_busy;
    int n_starts, n_pulses;
    logic [7:0] last_data, prev_data;

    task automatic model_reset();
        m_s1 = 1; m_s2 = 1; m_lvl = 1; m_pulse = 0; m_start = 0;
        m_queued = 0; m_overrun = 0; m_run = 0; m_phase = 0; m_seq = 0;
        m_data = 8'h00;
    endtask

    // Predict the effect of the coming rising edge from the inputs now driven
    task automatic model_edge();
        bit s, np, idle;
        if (!rst) begin
            model_reset();
            return;
        end
        s  = m_s2;
        np = 0;
        if (s != m_lvl) begin
            m_run++;
            if (m_run == int'(D)) begin
                m_lvl = s;
                m_run = 0;
                np    = !s;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = button;

        idle = (m_phase == 0);
        case (m_phase)
            0: if (m_pulse || m_queued) begin
                m_queued = 0;
                m_phase  = 1;
                if (!tx_busy) begin m_start = 1; m_data = 8'(m_seq); end
            end
            1: if (m_start) begin
                m_start = 0;
                m_phase = 2;
            end else if (!tx_busy) begin
                m_start = 1;
                m_data  = 8'(m_seq);
            end
            2: if (tx_busy) m_phase = 3;
            default: if (!tx_busy) begin
                m_phase = 0;
                m_seq   = (m_seq + 1) % 256;
            end
        endcase
        if (!idle && m_pulse) begin
            if (m_queued) m_overrun = 1;
            else          m_queued  = 1;
        end
        m_pulse = np;
    endtask

    // SPI master stand-in: busy rises 1..3 clocks after a start, lasts a while
    task automatic master_update();
        if (!rst) begin
            ms_wait = 0;
            ms_len  = 0;
        end else if (ms_len > 0) begin
            ms_len--;
        end else if (ms_wait > 0) begin
            ms_wait--;
            if (ms_wait == 0) ms_len = (ms_fix > 0) ? ms_fix : $urandom_range(1, 12);
        end else if (seen_start) begin
            ms_wait = $urandom_range(1, 3);
        end
        tx_busy = force_busy | (ms_len > 0);
    endtask

    task automatic compare();
        check("pressed", pressed, !m_lvl);
        check("press_pulse", press_pulse, m_pulse);
        check("tx_start", tx_start, m_start);
        if (m_start) check("tx_data", tx_data, m_data);
        check("overrun", overrun, m_overrun);
        seen_start = tx_start;
        if (tx_start) begin
            n_starts++;
            prev_data = last_data;
            last_data = tx_data;
        end
        if (press_pulse) n_pulses++;
    endtask

    task automatic step();
        master_update();
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic press_key(input int hold, input int gap);
        button = 1'b0;
        repeat (hold) step();
        button = 1'b1;
        repeat (gap) step();
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    initial begin
        int base, pulse_at, cyc;
        bit got;
        rst = 1'b0; button = 1'b0; tx_busy = 1'b0; force_busy = 0;
        ms_wait = 0; ms_len = 0; ms_fix = 0; seen_start = 0;
        n_starts = 0; n_pulses = 0; last_data = 8'h00; prev_data = 8'h00;
        model_reset();

        // 1: reset with the key held down, then release
        repeat (3) step();
        check("reset_tx_data", tx_data, 8'h00);
        check("reset_pressed", pressed, 1'b0);
        rst = 1'b1; button = 1'b1;
        repeat (30) step();
        check("reset_no_start", n_starts, 0);

        // 2: bouncing key, then held
        base = n_pulses;
        button = 1'b0; repeat (3) step();
        button = 1'b1; repeat (3) step();
        button = 1'b0;
        pulse_at = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (press_pulse && pulse_at < 0) pulse_at = i;
        end
        check("bounce_latency", pulse_at, 10);
        check("bounce_pulses", n_pulses - base, 1);
        check("bounce_pressed", pressed, 1'b1);
        button = 1'b1;
        repeat (30) step();
        check("first_data", last_data, 8'h00);

        // 3: single presses with an idle master
        press_key(D + 4, D + 20);
        check("second_data", last_data, 8'h01);
        press_key(D + 4, D + 20);
        check("third_data", last_data, 8'h02);

        // 4: master already busy before the press
        base = n_starts;
        force_busy = 1;
        press_key(D + 4, D + 10);
        check("busy_hold_no_start", n_starts - base, 0);
        force_busy = 0;
        step();
        check("busy_release_start", tx_start, 1'b1);
        repeat (40) step();

        // 5: queue and overrun during a long transfer
        base = n_starts;
        ms_fix = 70;
        repeat (3) press_key(D + 4, 14);
        repeat (200) step();
        ms_fix = 0;
        check("overrun_set", overrun, 1'b1);
        check("queued_transfers", n_starts - base, 2);

        // Random key activity after a fresh reset
        reset_pulse();
        check("overrun_cleared", overrun, 1'b0);
        cyc = 0;
        while (cyc < 2000) begin
            int len;
            button = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            repeat (len) step();
            cyc += len;
        end
        button = 1'b1;
        repeat (80) step();

        // 6: sequence wrap, then reset while waiting for busy
        reset_pulse();
        repeat (5) step();
        base = n_starts;
        repeat (257) press_key(D + 4, 14);
        repeat (40) step();
        check("wrap_count", n_starts - base, 257);
        check("wrap_ff", prev_data, 8'hff);
        check("wrap_00", last_data, 8'h00);

        button = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = seen_start;
        end
        check("start_before_reset", got, 1'b1);
        step();
        rst = 1'b0;
        repeat (2) step();
        check("reset_mid_start", tx_start, 1'b0);
        rst = 1'b1; button = 1'b1;
        base = n_starts;
        repeat (30) step();
        check("no_reissue", n_starts - base, 0);
        press_key(D + 4, D + 20);
        check("seq_after_reset", last_data, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
